ff_bank_arbiter: RTL and testbench
==================================

# ff_bank_arbiter

Round-robin arbiter and write sequencer that shares one WIDTH-bit D-flip-flop storage register among NREQ requesters. Each granted requester gets exactly one write into the register, then an acknowledge. The register drives true and complemented outputs, so it can replace a bank of single-bit D flip-flops wherever several producers must update the same stored value in the logic project.

## Interface
- WIDTH, 8, bit width of the shared register and of each requester's data word.
- NREQ, 4, number of requesters (2..8).
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  reset, asynchronous and active-low; clock is the single clock.
- req  in  NREQ  per-requester write request; level, held until its ack.
- data_in  in  NREQ*WIDTH  requester i data word in bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  one-hot grant, high only during LOAD.
- ack  out  NREQ  one-hot, one-cycle pulse in ACK: write completed.
- busy  out  1  high whenever state is not IDLE.
- q  out  WIDTH  stored register value.
- notq  out  WIDTH  bitwise complement of q, always exactly ~q.

## Operation
- States: IDLE, LOAD, ACK. Encoding is 2-bit binary, IDLE=0.
- IDLE:
  - If req is 0, stay in IDLE.
  - Otherwise select the winner: the first requester with req high, searching upward from the round-robin pointer ptr and wrapping modulo NREQ. Latch the winner index and go to LOAD.
- LOAD:
  - gnt[winner]=1.
  - At the end of this cycle, q loads the winner's data_in slice.
  - The write completes even if req[winner] drops during LOAD.
  - Go to ACK.
- ACK:
  - ack[winner]=1 for exactly one cycle.
  - ptr becomes (winner+1) mod NREQ.
  - Go to IDLE. New requests are not evaluated in ACK.
- The requester drops req on the cycle after it sees ack. If req is still high in IDLE, it competes again, with lowest priority relative to the rotated ptr.
- A req that drops in IDLE before it wins is withdrawn; no state is kept for it.
- Simultaneous requests are resolved purely by ptr order. No requester waits more than NREQ-1 other grants.
- q changes only at the end of LOAD. notq tracks q combinationally from the same register.
- Reset at any time, including mid-LOAD:
  - state=IDLE, ptr=0, gnt=0, ack=0, busy=0.
  - q=all zeros, notq=all ones.
  - A pending write is discarded.

## Timing
- req[i] high before edge 0 with the arbiter idle and i winning:
  - LOAD during cycle 0→1: gnt[i]=1, busy=1.
  - q valid after edge 1.
  - ACK during cycle 1→2: ack[i]=1.
  - IDLE after edge 2.
- One write per 3 cycles maximum throughput. Back-to-back requests from different requesters give gnt pulses 3 cycles apart.
- All outputs are registered or decoded directly from state and winner; there is no combinational path from req to gnt or ack.
- data_in is sampled only at the LOAD→ACK edge and must be stable during LOAD.
- reset_n assertion clears state immediately, without waiting for a clock edge. Deassertion is synchronous to clock by the system; the first possible grant is the edge after release.

## Structure
- Shared package ff_arb_pkg holds:
  - the state encoding constants ST_IDLE, ST_LOAD, ST_ACK;
  - a clog2 function for the ptr/winner width;
  - default WIDTH and NREQ.
- Sub-module ff_d_bank: WIDTH-bit register with clock, reset_n, load enable and d, producing q and notq. Reset value is q=0, notq=all ones.
- The top level contains the FSM, the round-robin search (a rotate, priority-encode and un-rotate) and the data mux.

## Test plan
- Reset: reset_n=0 mid-LOAD with data 0xA5. Required: immediately q=0x00, notq=0xFF, gnt=0, busy=0. After release, no ack appears.
- Single write: req=0001, data0=0x3C. Required: gnt=0001 for one cycle, then q=0x3C, notq=0xC3, and ack=0001 one cycle later.
- Contention: from reset, req=1111 held, each requester dropping its req after its ack. Required: grant order 0,1,2,3; q sequence equals data0..data3; writes 3 cycles apart.
- Rotation: after granting requester 2, req=0101. Required: the next grant goes to requester 0 (search wraps past 3), not 2.
- Early drop: req[1] drops during LOAD with data1=0x7E. Required: q=0x7E and ack[1] still pulses.
- Withdrawn request: req[3] pulses high only while requester 0 is in LOAD. Required: requester 3 is never granted, and q reflects only the data0 write.

Source files
------------

// File: rtl/ff_arb_pkg.sv
// Shared types and constants for the shared-register
// round-robin arbiter.
package ff_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ff_d_bank.sv
// WIDTH-bit D register with load enable and
// true/complement outputs.
module ff_d_bank
  import ff_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_notq
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q    = r_q;
  assign o_notq = ~r_q;

endmodule

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter sequencing one write per grant
// into a shared D register bank.
module ff_bank_arbiter
  import ff_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      notq
);

  localparam int PW = clog2(NREQ);
  localparam logic [PW:0] NR = (PW+1)'(NREQ);

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_win;
  logic [PW-1:0]     w_win;
  logic [PW-1:0]     w_off;
  logic [PW-1:0]     w_ptr_nxt;
  logic [PW:0]       w_sum;
  logic [PW:0]       w_inc;
  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_onehot;
  logic              w_any;
  logic              w_load;
  logic [WIDTH-1:0]  w_d;

  // rotate so ptr sits at bit 0, pick lowest, un-rotate
  assign w_dbl = {req, req} >> r_ptr;
  assign w_rot = w_dbl[NREQ-1:0];
  assign w_any = |req;

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
  end

  assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win = (w_sum >= NR) ? PW'(w_sum - NR)
                               : w_sum[PW-1:0];

  assign w_inc     = {1'b0, r_win} + (PW+1)'(1);
  assign w_ptr_nxt = (w_inc == NR) ? '0 : w_inc[PW-1:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_ACK;
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_any) r_win <= w_win;
      if (r_state == ST_ACK) r_ptr <= w_ptr_nxt;
    end
  end

  assign w_onehot = NREQ'(1) << r_win;
  assign w_load   = (r_state == ST_LOAD);
  assign gnt      = w_load ? w_onehot : '0;
  assign ack      = (r_state == ST_ACK) ? w_onehot : '0;
  assign busy     = (r_state != ST_IDLE);
  assign w_d      = data_in[int'(r_win)*WIDTH +: WIDTH];

  ff_d_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .i_clk  (clock),
    .i_rst_n(reset_n),
    .i_load (w_load),
    .i_d    (w_d),
    .o_q    (q),
    .o_notq (notq)
  );

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter with
// hand-computed expectations.
module tb_ff_bank_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clock;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           busy;
  logic [W-1:0]   q;
  logic [W-1:0]   notq;

  int n_pass;
  int n_tot;

  ff_bank_arbiter #(
    .WIDTH(W),
    .NREQ (N)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .data_in(data_in),
    .gnt    (gnt),
    .ack    (ack),
    .busy   (busy),
    .q      (q),
    .notq   (notq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  initial begin
    logic [W-1:0] dv [4];
    n_pass  = 0;
    n_tot   = 0;
    req     = '0;
    data_in = '0;
    reset_n = 1'b0;
    #2;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_notq", 32'(notq), 32'hFF);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // single write
    req = 4'b0001;
    set_d(0, 8'h3C);
    tick();
    chk("sw_gnt", 32'(gnt), 32'h1);
    chk("sw_busy", 32'(busy), 32'h1);
    chk("sw_q_hold", 32'(q), 32'h00);
    chk("sw_ack0", 32'(ack), 32'h0);
    tick();
    chk("sw_q", 32'(q), 32'h3C);
    chk("sw_notq", 32'(notq), 32'hC3);
    chk("sw_ack", 32'(ack), 32'h1);
    chk("sw_gnt_off", 32'(gnt), 32'h0);
    req = 4'b0000;
    tick();
    chk("sw_ack_off", 32'(ack), 32'h0);
    chk("sw_idle", 32'(busy), 32'h0);

    // async reset in the middle of LOAD
    req = 4'b0001;
    set_d(0, 8'hA5);
    tick();
    chk("mr_gnt", 32'(gnt), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_q", 32'(q), 32'h00);
    chk("mr_notq", 32'(notq), 32'hFF);
    chk("mr_gnt0", 32'(gnt), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    req = 4'b0000;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mr_no_ack", 32'(ack), 32'h0);
      chk("mr_q_keep", 32'(q), 32'h00);
    end

    // contention from reset: order 0,1,2,3
    dv[0] = 8'h11;
    dv[1] = 8'h22;
    dv[2] = 8'h33;
    dv[3] = 8'h44;
    for (int i = 0; i < N; i++) set_d(i, dv[i]);
    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      tick();
      chk("ct_gnt", 32'(gnt), 32'(1 << i));
      chk("ct_q_pre", 32'(q), (i == 0) ? 32'h0 : 32'(dv[i-1]));
      tick();
      chk("ct_q", 32'(q), 32'(dv[i]));
      chk("ct_ack", 32'(ack), 32'(1 << i));
      req[i] = 1'b0;
      tick();
      chk("ct_idle", 32'(busy), 32'h0);
      chk("ct_gnt_gap", 32'(gnt), 32'h0);
    end

    // rotation: grant 2 then 0101 must wrap to 0
    set_d(0, 8'h5C);
    set_d(2, 8'hC5);
    req = 4'b0100;
    tick();
    chk("rot_g2", 32'(gnt), 32'h4);
    tick();
    chk("rot_a2", 32'(ack), 32'h4);
    chk("rot_q2", 32'(q), 32'hC5);
    req = 4'b0101;
    tick();
    chk("rot_idle", 32'(gnt), 32'h0);
    tick();
    chk("rot_g0", 32'(gnt), 32'h1);
    tick();
    chk("rot_q0", 32'(q), 32'h5C);
    chk("rot_a0", 32'(ack), 32'h1);
    req = 4'b0000;
    tick();

    // early drop of req[1] during LOAD
    set_d(1, 8'h7E);
    req = 4'b0010;
    tick();
    chk("ed_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("ed_q", 32'(q), 32'h7E);
    chk("ed_notq", 32'(notq), 32'h81);
    chk("ed_ack", 32'(ack), 32'h2);
    tick();

    // withdrawn req[3] only during requester 0 LOAD
    set_d(0, 8'h5A);
    set_d(3, 8'h99);
    req = 4'b0001;
    tick();
    chk("wd_gnt", 32'(gnt), 32'h1);
    req = 4'b1001;
    tick();
    chk("wd_ack", 32'(ack), 32'h1);
    chk("wd_q", 32'(q), 32'h5A);
    req = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wd_no_gnt", 32'(gnt), 32'h0);
      chk("wd_busy", 32'(busy), 32'h0);
      chk("wd_q_keep", 32'(q), 32'h5A);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
